// File: rtl/rv_ipdom_stack_mw.sv
// rv_ipdom_stack_mw
//   Multi-warp IPDOM reconvergence stack. Each warp owns DEPTH slots in a
//   shared storage array. A slot holds {is_part, q2, q1}.
//   - A split pair is pushed with is_part=0. Its first pop returns q2 and
//     marks the entry is_part=1. Its second pop returns q1 and retires it.
//   - A single entry is pushed with is_part=1. Its one pop returns q1.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   push, push_wid         push request and target warp
//   pair, q1, q2           entry kind, join data, else data
//   pop, pop_wid           pop request and target warp
//   pop_valid              registered response strobe, one cycle after the pop
//   pop_wid_out, pop_data  response warp and data; both hold while idle
//   pop_index              1 = q1 returned (entry retired), 0 = q2 returned
//   empty, full, count     per-warp occupancy. count is packed, warp 0 in the LSBs
//   err_overflow           sticky per-warp flag: push to a full warp
//   err_underflow          sticky per-warp flag: pop from an empty warp
//   err_conflict           sticky flag: push and pop to the same warp in one cycle
module rv_ipdom_stack_mw #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_WARPS = 4,
  parameter int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int CNTW      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDW-1:0]           push_wid,
  input  logic                      pair,
  input  logic [WIDTH-1:0]          q1,
  input  logic [WIDTH-1:0]          q2,
  input  logic                      pop,
  input  logic [WIDW-1:0]           pop_wid,
  output logic                      pop_valid,
  output logic [WIDW-1:0]           pop_wid_out,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      pop_index,
  output logic [NUM_WARPS-1:0]      empty,
  output logic [NUM_WARPS-1:0]      full,
  output logic [NUM_WARPS*CNTW-1:0] count,
  output logic [NUM_WARPS-1:0]      err_overflow,
  output logic [NUM_WARPS-1:0]      err_underflow,
  output logic                      err_conflict
);

  localparam int ENTRIES = NUM_WARPS * DEPTH;
  localparam int ADDRW   = $clog2(ENTRIES);
  localparam int SLOTW   = $clog2(DEPTH);

  logic [CNTW-1:0]  cnt      [NUM_WARPS];
  logic             is_part  [ENTRIES];
  logic [WIDTH-1:0] mem_q1   [ENTRIES];
  logic [WIDTH-1:0] mem_q2   [ENTRIES];

  // With a single warp, the warp-id ports are 1 bit wide but only warp 0 exists.
  logic [WIDW-1:0]  push_w, pop_w;
  logic [SLOTW-1:0] push_slot, top_slot;
  logic [ADDRW-1:0] push_addr, top_addr;
  logic             push_ok, pop_ok, same_warp, top_part;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    count = '0;
    empty = '0;
    full  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      count[w*CNTW +: CNTW] = cnt[w];
      empty[w] = (cnt[w] == '0);
      full[w]  = (cnt[w] == CNTW'(DEPTH));
    end
  end

  assign push_w    = (NUM_WARPS == 1) ? '0 : push_wid;
  assign pop_w     = (NUM_WARPS == 1) ? '0 : pop_wid;
  assign same_warp = push && pop && (push_w == pop_w);
  assign push_ok   = push && !full[push_w];
  assign pop_ok    = pop && !empty[pop_w] && !same_warp;

  // Slot and address arithmetic. The result is used only when the matching
  // *_ok is set, so wrap-around on a full or empty warp does no harm.
  assign push_slot = SLOTW'(cnt[push_w]);
  assign top_slot  = SLOTW'(cnt[pop_w] - CNTW'(1));
  assign push_addr = ADDRW'(int'(push_w) * DEPTH + int'(push_slot));
  assign top_addr  = ADDRW'(int'(pop_w) * DEPTH + int'(top_slot));
  assign top_part  = is_part[top_addr];

  // Counts and is_part update at the edge. A pop in the next cycle therefore
  // reads the state that the previous pop left, with no stall needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) cnt[w] <= '0;
      for (int e = 0; e < ENTRIES; e++) is_part[e] <= 1'b0;
      pop_valid     <= 1'b0;
      pop_wid_out   <= '0;
      pop_data      <= '0;
      pop_index     <= 1'b0;
      err_overflow  <= '0;
      err_underflow <= '0;
      err_conflict  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every read sees pre-edge values.
      pop_valid <= pop_ok;
      if (pop_ok) begin
        pop_wid_out <= pop_w;
        pop_index   <= top_part;
        pop_data    <= top_part ? mem_q1[top_addr] : mem_q2[top_addr];
        if (top_part) cnt[pop_w] <= cnt[pop_w] - CNTW'(1);
        else          is_part[top_addr] <= 1'b1;
      end
      // pop_ok excludes the push warp, so these two updates never touch the same count.
      if (push_ok) begin
        is_part[push_addr] <= ~pair;
        cnt[push_w]        <= cnt[push_w] + CNTW'(1);
      end
      if (push && full[push_w])              err_overflow[push_w]  <= 1'b1;
      if (pop && empty[pop_w] && !same_warp) err_underflow[pop_w]  <= 1'b1;
      if (same_warp)                         err_conflict          <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset. Only counts and is_part decide validity, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q1[push_addr] <= q1;
      mem_q2[push_addr] <= q2;
    end
  end

endmodule

// File: tb/tb_rv_ipdom_stack_mw.sv
// tb_rv_ipdom_stack_mw
//   Scoreboard bench for rv_ipdom_stack_mw with the default parameters.
//   Expected responses are queued when a pop is driven. A negedge monitor
//   pops the queue and compares it with each pop_valid response.
module tb_rv_ipdom_stack_mw;

  localparam int WIDTH = 8, DEPTH = 4, NW = 4, WIDW = 2, CNTW = 3;

  logic             clk = 1'b0;
  logic             reset, push, pair, pop;
  logic [WIDW-1:0]  push_wid, pop_wid;
  logic [WIDTH-1:0] q1, q2;
  logic             pop_valid, pop_index, err_conflict;
  logic [WIDW-1:0]  pop_wid_out;
  logic [WIDTH-1:0] pop_data;
  logic [NW-1:0]    empty, full, err_overflow, err_underflow;
  logic [NW*CNTW-1:0] count;

  typedef struct packed {
    logic [WIDW-1:0]  wid;
    logic [WIDTH-1:0] data;
    logic             idx;
  } resp_t;

  resp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  rv_ipdom_stack_mw #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WARPS(NW)) dut (
    .clk(clk), .reset(reset), .push(push), .push_wid(push_wid), .pair(pair),
    .q1(q1), .q2(q2), .pop(pop), .pop_wid(pop_wid), .pop_valid(pop_valid),
    .pop_wid_out(pop_wid_out), .pop_data(pop_data), .pop_index(pop_index),
    .empty(empty), .full(full), .count(count), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNTW-1:0] cnt_of(input int w);
    return count[w*CNTW +: CNTW];
  endfunction

  // Response monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (pop_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop_valid", 32'(pop_valid), 32'd0);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        check("resp_data",  32'(pop_data),    32'(e.data));
        check("resp_index", 32'(pop_index),   32'(e.idx));
        check("resp_wid",   32'(pop_wid_out), 32'(e.wid));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus, then returns the inputs to idle.
  task automatic drive(input bit ps, input int pw, input bit pr, input int a1, input int a2,
                       input bit pp, input int ppw);
    push = ps; push_wid = WIDW'(pw); pair = pr; q1 = WIDTH'(a1); q2 = WIDTH'(a2);
    pop = pp; pop_wid = WIDW'(ppw);
    tick();
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic push_only(input int w, input bit pr, input int a1, input int a2);
    drive(1'b1, w, pr, a1, a2, 1'b0, 0);
  endtask

  task automatic pop_exp(input int w, input int data, input bit idx);
    resp_t e;
    e.wid = WIDW'(w); e.data = WIDTH'(data); e.idx = idx;
    sb_q.push_back(e);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1, w);
  endtask

  task automatic pop_none(input int w);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1, w);
  endtask

  task automatic idle();
    tick();
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; pair = 1'b0;
    push_wid = '0; pop_wid = '0; q1 = '0; q2 = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_empty",     32'(empty), 32'hF);
    check("rst_full",      32'(full), 32'h0);
    check("rst_count",     32'(count), 32'h0);
    check("rst_pop_valid", 32'(pop_valid), 32'h0);
    check("rst_errs",      32'({err_overflow, err_underflow, err_conflict}), 32'h0);

    // A pair returns q2 first and then q1.
    push_only(0, 1'b1, 'h11, 'h22);
    check("t1_count0", 32'(cnt_of(0)), 32'd1);
    pop_exp(0, 'h22, 1'b0);
    check("t1_count0_retained", 32'(cnt_of(0)), 32'd1);
    pop_exp(0, 'h11, 1'b1);
    idle();
    check("t1_empty0", 32'(empty[0]), 32'd1);

    // A single entry pops once. The next pop underflows.
    push_only(2, 1'b0, 'hA5, 'h00);
    check("t2_count2", 32'(cnt_of(2)), 32'd1);
    pop_exp(2, 'hA5, 1'b1);
    check("t2_count2_after", 32'(cnt_of(2)), 32'd0);
    pop_none(2);
    idle();
    check("t2_underflow", 32'(err_underflow), 32'b0100);

    // Fill warp 1, then overflow it.
    for (int i = 0; i < DEPTH; i++) push_only(1, 1'b0, 'h10 + i, 'h00);
    check("t3_full1",  32'(full), 32'b0010);
    check("t3_count1", 32'(cnt_of(1)), 32'd4);
    push_only(1, 1'b0, 'h99, 'h00);
    check("t3_overflow",  32'(err_overflow), 32'b0010);
    check("t3_count1_ov", 32'(cnt_of(1)), 32'd4);
    pop_exp(1, 'h13, 1'b1);
    check("t3_count1_pop", 32'(cnt_of(1)), 32'd3);

    // A push and a pop to different warps in the same cycle.
    push_only(0, 1'b1, 'h55, 'h44);
    begin
      resp_t e;
      e.wid = 2'd0; e.data = 8'h44; e.idx = 1'b0;
      sb_q.push_back(e);
    end
    drive(1'b1, 3, 1'b0, 'h33, 'h00, 1'b1, 0);
    check("t4_count3", 32'(cnt_of(3)), 32'd1);
    check("t4_count0", 32'(cnt_of(0)), 32'd1);

    // A push and a pop to the same warp: the push lands and the pop is dropped.
    drive(1'b1, 0, 1'b0, 'h66, 'h00, 1'b1, 0);
    idle();
    check("t5_conflict", 32'(err_conflict), 32'd1);
    check("t5_count0",   32'(cnt_of(0)), 32'd2);
    check("t5_no_uf0",   32'(err_underflow[0]), 32'd0);
    pop_exp(0, 'h66, 1'b1);
    pop_exp(0, 'h55, 1'b1);
    idle();
    check("t5_count0_drained", 32'(cnt_of(0)), 32'd0);

    // Nested entries, back-to-back pops, then underflow.
    push_only(0, 1'b1, 'h01, 'h02);
    push_only(0, 1'b0, 'h03, 'h00);
    pop_exp(0, 'h03, 1'b1);
    pop_exp(0, 'h02, 1'b0);
    pop_exp(0, 'h01, 1'b1);
    pop_none(0);
    check("t6_underflow0", 32'(err_underflow[0]), 32'd1);

    // Reset wins over a pop in the same cycle.
    reset = 1'b1; pop = 1'b1; pop_wid = 2'd1;
    tick();
    reset = 1'b0; pop = 1'b0;
    check("t6_rst_empty",  32'(empty), 32'hF);
    check("t6_rst_count",  32'(count), 32'h0);
    check("t6_rst_errs",   32'({err_overflow, err_underflow, err_conflict}), 32'h0);
    check("t6_rst_resp",   32'({pop_valid, pop_index, pop_wid_out, pop_data}), 32'h0);
    idle(); idle();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
